// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with one write port, two registered read ports,
// a per-register pending-write scoreboard for RAW detection, optional
// write-first bypass and an NZP condition-code register.
//
// Reserve handshake: decode samples RESV_FULL (combinational from pending and
// RESV_DR) before raising RESV for one cycle; a reservation is counted on the
// edge where RESV=1 and shows in SRx_BUSY from that same edge. A RESV issued
// while RESV_FULL=1 is dropped and raises SB_ERR.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int PEND_W   = 2,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              LD_REG,
  input  logic [ADDR_W-1:0] DR,
  input  logic              SET_CC,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  output logic [DATA_W-1:0] SR1_OUT,
  output logic [DATA_W-1:0] SR2_OUT,
  output logic              SR1_BUSY,
  output logic              SR2_BUSY,
  input  logic              RESV,
  input  logic [ADDR_W-1:0] RESV_DR,
  output logic              RESV_FULL,
  input  logic              FLUSH,
  output logic              SB_ERR,
  output logic [2:0]        CC
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [PEND_W-1:0] pend     [NUM_REGS];
  logic [PEND_W-1:0] pend_nxt [NUM_REGS];
  logic              inc      [NUM_REGS];
  logic              dec      [NUM_REGS];

  logic              dr_ok, rdr_ok, s1_ok, s2_ok;
  logic              err_set;
  logic [DATA_W-1:0] rd1_nxt, rd2_nxt;
  logic              busy1_nxt, busy2_nxt;
  logic [2:0]        cc_nxt;

  // Indices beyond the populated depth are treated as absent registers.
  assign dr_ok  = int'(DR)      < NUM_REGS;
  assign rdr_ok = int'(RESV_DR) < NUM_REGS;
  assign s1_ok  = int'(SR1)     < NUM_REGS;
  assign s2_ok  = int'(SR2)     < NUM_REGS;

  assign RESV_FULL = rdr_ok && (pend[RESV_DR] == PEND_MAX);

  // Next pending count per register: saturating reserve, guarded release, flush wins.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i]      = RESV && (RESV_DR == ADDR_W'(i)) && (pend[i] != PEND_MAX);
      dec[i]      = LD_REG && (DR == ADDR_W'(i)) && (pend[i] != '0);
      pend_nxt[i] = pend[i];
      if (FLUSH)
        pend_nxt[i] = '0;
      else if (inc[i] && !dec[i])
        pend_nxt[i] = pend[i] + 1'b1;
      else if (dec[i] && !inc[i])
        pend_nxt[i] = pend[i] - 1'b1;
    end
  end

  // Error sources, read data/busy next values and condition-code decode.
  always_comb begin
    err_set = !FLUSH &&
              ((RESV && rdr_ok && (pend[RESV_DR] == PEND_MAX)) ||
               (LD_REG && dr_ok && (pend[DR] == '0)));

    rd1_nxt = '0;
    if (s1_ok)
      rd1_nxt = ((BYPASS != 0) && LD_REG && (DR == SR1)) ? data : regs[SR1];
    rd2_nxt = '0;
    if (s2_ok)
      rd2_nxt = ((BYPASS != 0) && LD_REG && (DR == SR2)) ? data : regs[SR2];

    busy1_nxt = s1_ok && (pend_nxt[SR1] != '0);
    busy2_nxt = s2_ok && (pend_nxt[SR2] != '0);

    cc_nxt = {data[DATA_W-1], data == '0, !data[DATA_W-1] && (data != '0)};
  end

  // Register storage and pending counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (LD_REG && (DR == ADDR_W'(i)))
          regs[i] <= data;
        pend[i] <= pend_nxt[i];
      end
    end
  end

  // Registered read ports, busy flags, sticky error and condition codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SR1_OUT  <= '0;
      SR2_OUT  <= '0;
      SR1_BUSY <= 1'b0;
      SR2_BUSY <= 1'b0;
      SB_ERR   <= 1'b0;
      CC       <= 3'b010;
    end else begin
      SR1_OUT  <= rd1_nxt;
      SR2_OUT  <= rd2_nxt;
      SR1_BUSY <= busy1_nxt;
      SR2_BUSY <= busy2_nxt;
      if (err_set)
        SB_ERR <= 1'b1;
      if (LD_REG && SET_CC)
        CC <= cc_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard bench for reg_file_sb. Two instances
// share the write/reserve inputs: dut with BYPASS=1, dut_nb with BYPASS=0
// (its SR2 is tied to R0, which is never written).
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic        ld_reg = 1'b0;
  logic [2:0]  dr = '0;
  logic        set_cc = 1'b0;
  logic [2:0]  sr1 = '0;
  logic [2:0]  sr2 = '0;
  logic        resv = 1'b0;
  logic [2:0]  resv_dr = '0;
  logic        flush = 1'b0;

  logic [15:0] sr1_out, sr2_out, nb_sr1, nb_sr2;
  logic        sr1_busy, sr2_busy, nb_b1, nb_b2;
  logic        resv_full, nb_full, sb_err, nb_err;
  logic [2:0]  cc, nb_cc;

  int checks = 0;
  int errors = 0;

  // Expected record: {cc[53:51], err[50], b2[49], b1[48], nb_sr1[47:32], sr2[31:16], sr1[15:0]}
  logic [53:0] exp_q[$];

  reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .PEND_W(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .LD_REG(ld_reg), .DR(dr),
    .SET_CC(set_cc), .SR1(sr1), .SR2(sr2), .SR1_OUT(sr1_out), .SR2_OUT(sr2_out),
    .SR1_BUSY(sr1_busy), .SR2_BUSY(sr2_busy), .RESV(resv), .RESV_DR(resv_dr),
    .RESV_FULL(resv_full), .FLUSH(flush), .SB_ERR(sb_err), .CC(cc)
  );

  reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .PEND_W(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .data(data), .LD_REG(ld_reg), .DR(dr),
    .SET_CC(set_cc), .SR1(sr1), .SR2(3'd0), .SR1_OUT(nb_sr1), .SR2_OUT(nb_sr2),
    .SR1_BUSY(nb_b1), .SR2_BUSY(nb_b2), .RESV(resv), .RESV_DR(resv_dr),
    .RESV_FULL(nb_full), .FLUSH(flush), .SB_ERR(nb_err), .CC(nb_cc)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge, check the
  // combinational RESV_FULL, and queue the outputs expected after the next rise.
  task automatic cyc(input logic ld, input logic [2:0] d_r, input logic [15:0] d,
                     input logic scc, input logic [2:0] s1, input logic [2:0] s2,
                     input logic rv, input logic [2:0] rdr, input logic fl,
                     input logic efull, input logic [15:0] e1, input logic [15:0] e2,
                     input logic [15:0] enb, input logic eb1, input logic eb2,
                     input logic eerr, input logic [2:0] ecc);
    @(negedge clk);
    ld_reg = ld; dr = d_r; data = d; set_cc = scc; sr1 = s1; sr2 = s2;
    resv = rv; resv_dr = rdr; flush = fl;
    #1;
    chk("resv_full", {15'd0, resv_full}, {15'd0, efull});
    chk("nb_resv_full", {15'd0, nb_full}, {15'd0, efull});
    exp_q.push_back({ecc, eerr, eb2, eb1, enb, e2, e1});
  endtask

  task automatic idle_inputs();
    ld_reg = 1'b0; dr = '0; data = '0; set_cc = 1'b0; sr1 = '0; sr2 = '0;
    resv = 1'b0; resv_dr = '0; flush = 1'b0;
  endtask

  // Assert reset away from the clock edge, check outputs respond at once, release.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_sr1", sr1_out, 16'h0000);
    chk("rst_sr2", sr2_out, 16'h0000);
    chk("rst_busy", {14'd0, sr2_busy, sr1_busy}, 16'h0000);
    chk("rst_err", {15'd0, sb_err}, 16'h0000);
    chk("rst_cc", {13'd0, cc}, 16'h0002);
    chk("rst_full", {15'd0, resv_full}, 16'h0000);
    chk("rst_nb_sr1", nb_sr1, 16'h0000);
    chk("rst_nb_cc", {13'd0, nb_cc}, 16'h0002);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one output set per rising edge while expectations are queued.
  always @(posedge clk) begin
    logic [53:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sr1_out", sr1_out, e[15:0]);
      chk("sr2_out", sr2_out, e[31:16]);
      chk("nb_sr1_out", nb_sr1, e[47:32]);
      chk("nb_sr2_out", nb_sr2, 16'h0000);
      chk("sr1_busy", {15'd0, sr1_busy}, {15'd0, e[48]});
      chk("sr2_busy", {15'd0, sr2_busy}, {15'd0, e[49]});
      chk("nb_sr1_busy", {15'd0, nb_b1}, {15'd0, e[48]});
      chk("nb_sr2_busy", {15'd0, nb_b2}, 16'h0000);
      chk("sb_err", {15'd0, sb_err}, {15'd0, e[50]});
      chk("nb_sb_err", {15'd0, nb_err}, {15'd0, e[50]});
      chk("cc", {13'd0, cc}, {13'd0, e[53:51]});
      chk("nb_cc", {13'd0, nb_cc}, {13'd0, e[53:51]});
    end
  end

  // Directed stimulus: ld,dr,data,scc, sr1,sr2, resv,resv_dr,flush |
  // full, sr1,sr2,nb_sr1, busy1,busy2, err, cc
  initial begin
    idle_inputs();
    do_reset();

    // Unreserved write of R3, then asynchronous reset wipes it.
    cyc(1, 3, 16'h1234, 0, 3, 0, 0, 0, 0,  0, 16'h1234, 16'h0, 16'h0000, 0, 0, 1, 3'b010);
    cyc(0, 0, 16'h0000, 0, 3, 0, 0, 0, 0,  0, 16'h1234, 16'h0, 16'h1234, 0, 0, 1, 3'b010);
    do_reset();
    cyc(0, 0, 16'h0000, 0, 3, 0, 0, 0, 0,  0, 16'h0000, 16'h0, 16'h0000, 0, 0, 0, 3'b010);

    // Bypass: reserve R5, write 0xBEEF while reading it on both ports.
    cyc(0, 0, 16'h0000, 0, 5, 0, 1, 5, 0,  0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 3'b010);
    cyc(1, 5, 16'hBEEF, 0, 5, 5, 0, 5, 0,  0, 16'hBEEF, 16'hBEEF, 16'h0000, 0, 0, 0, 3'b010);
    cyc(0, 0, 16'h0000, 0, 5, 0, 0, 0, 0,  0, 16'hBEEF, 16'h0000, 16'hBEEF, 0, 0, 0, 3'b010);

    // Condition codes via R1 (three reservations, then three SET_CC writes).
    cyc(0, 0, 16'h0000, 0, 1, 1, 1, 1, 0,  0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 3'b010);
    cyc(0, 0, 16'h0000, 0, 1, 1, 1, 1, 0,  0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 3'b010);
    cyc(0, 0, 16'h0000, 0, 1, 1, 1, 1, 0,  0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 3'b010);
    cyc(1, 1, 16'h8000, 1, 1, 1, 0, 1, 0,  1, 16'h8000, 16'h8000, 16'h0000, 1, 1, 0, 3'b100);
    cyc(1, 1, 16'h0000, 1, 1, 1, 0, 1, 0,  0, 16'h0000, 16'h0000, 16'h8000, 1, 1, 0, 3'b010);
    cyc(1, 1, 16'h0001, 1, 1, 1, 0, 1, 0,  0, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0, 3'b001);
    cyc(0, 0, 16'h0000, 0, 1, 1, 1, 1, 0,  0, 16'h0001, 16'h0001, 16'h0001, 1, 1, 0, 3'b001);
    cyc(1, 1, 16'h8000, 0, 1, 1, 0, 1, 0,  0, 16'h8000, 16'h8000, 16'h0001, 0, 0, 0, 3'b001);

    // Simultaneous reserve/write on R4, then flush with reserve, then flush with write.
    cyc(0, 0, 16'h0000, 0, 4, 4, 1, 4, 0,  0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 3'b001);
    cyc(1, 4, 16'h0044, 0, 4, 4, 1, 4, 0,  0, 16'h0044, 16'h0044, 16'h0000, 1, 1, 0, 3'b001);
    cyc(0, 0, 16'h0000, 0, 4, 4, 1, 4, 1,  0, 16'h0044, 16'h0044, 16'h0044, 0, 0, 0, 3'b001);
    cyc(1, 4, 16'h0055, 0, 4, 4, 0, 4, 1,  0, 16'h0055, 16'h0055, 16'h0044, 0, 0, 0, 3'b001);
    cyc(0, 0, 16'h0000, 0, 4, 4, 0, 4, 0,  0, 16'h0055, 16'h0055, 16'h0055, 0, 0, 0, 3'b001);

    // Saturation on R2: three reserves fill it, a fourth errors and is dropped.
    cyc(0, 0, 16'h0000, 0, 2, 0, 1, 2, 0,  0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 3'b001);
    cyc(0, 0, 16'h0000, 0, 2, 0, 1, 2, 0,  0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 3'b001);
    cyc(0, 0, 16'h0000, 0, 2, 0, 1, 2, 0,  0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 3'b001);
    cyc(0, 0, 16'h0000, 0, 2, 0, 1, 2, 0,  1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 3'b001);
    cyc(1, 2, 16'h0A0A, 0, 2, 0, 0, 2, 0,  1, 16'h0A0A, 16'h0000, 16'h0000, 1, 0, 1, 3'b001);
    cyc(1, 2, 16'h0B0B, 0, 2, 0, 0, 2, 0,  0, 16'h0B0B, 16'h0000, 16'h0A0A, 1, 0, 1, 3'b001);
    cyc(1, 2, 16'h0C0C, 0, 2, 0, 0, 2, 0,  0, 16'h0C0C, 16'h0000, 16'h0B0B, 0, 0, 1, 3'b001);

    // Unmatched write to R6 after a fresh reset: written, error sticks.
    do_reset();
    cyc(0, 0, 16'h0000, 0, 2, 0, 0, 0, 0,  0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 3'b010);
    cyc(1, 6, 16'h0666, 0, 6, 0, 0, 6, 0,  0, 16'h0666, 16'h0000, 16'h0000, 0, 0, 1, 3'b010);
    cyc(0, 0, 16'h0000, 0, 6, 0, 0, 0, 0,  0, 16'h0666, 16'h0000, 16'h0666, 0, 0, 1, 3'b010);
    cyc(0, 0, 16'h0000, 0, 6, 0, 0, 0, 0,  0, 16'h0666, 16'h0000, 16'h0666, 0, 0, 1, 3'b010);
    do_reset();

    @(posedge clk);
    #2;
    chk("exp_q_drained", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
